// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment display path.
// Segment patterns are active-high, ordered {g,f,e,d,c,b,a}.
package seg_pkg;
  localparam int NUM_DIGITS = 6;
  localparam int SEG_W      = 7;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;
endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-high 7-segment decoder.
// Codes above 9 decode to an unlit digit.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0]       i_bcd,
  output logic [SEG_W-1:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// Six-digit 7-segment scanner: per-frame snapshot, anti-ghost blanking, registered outputs.
// Optional LEAD_ZERO_BLANK_EN suppresses leading zeros on the two hours digits.
module seg_scan
  import seg_pkg::*;
#(
  parameter int DIV            = 50,
  parameter int BLANK          = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                  fs,
  input  logic                  rst_n,
  input  logic [3:0]            a,
  input  logic [3:0]            b,
  input  logic [3:0]            c,
  input  logic [3:0]            d,
  input  logic [3:0]            e,
  input  logic [3:0]            f,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  output logic [SEG_W-1:0]      seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] sel
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [SEG_W-1:0]      SEG_OFF = {SEG_W{SEG_ACTIVE_LOW}};
  localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{SEL_ACTIVE_LOW}};

  logic [CNT_W-1:0]        r_cnt;
  logic [2:0]              r_idx;
  logic                    r_first;
  logic [4*NUM_DIGITS-1:0] r_snap;
  logic [NUM_DIGITS-1:0]   r_dpm;
  logic [SEG_W-1:0]        r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_sel;

  logic [4*NUM_DIGITS-1:0] w_live;
  logic [4*NUM_DIGITS-1:0] w_src;
  logic [NUM_DIGITS-1:0]   w_dpsrc;
  logic [3:0]              w_digit;
  logic [SEG_W-1:0]        w_seg_ah;
  logic [SEG_W-1:0]        w_seg_on;
  logic                    w_lz;
  logic                    w_wrap;
  logic                    w_snap_en;
  logic                    w_sel_on;
  logic [NUM_DIGITS-1:0]   w_hot;

  assign w_live = {f, e, d, c, b, a};

  // The first cycle after reset decodes the live inputs so frame 0 matches its own snapshot.
  assign w_src   = r_first ? w_live : r_snap;
  assign w_dpsrc = r_first ? dp_mask : r_dpm;
  assign w_digit = w_src[{r_idx, 2'b00} +: 4];

  bcd_to_seg u_dec (
    .i_bcd (w_digit),
    .o_seg (w_seg_ah)
  );

`ifdef LEAD_ZERO_BLANK_EN
  assign w_lz = ((r_idx == 3'd5) && (w_src[23:20] == 4'd0)) ||
                ((r_idx == 3'd4) && (w_src[23:20] == 4'd0) && (w_src[19:16] == 4'd0));
`else
  assign w_lz = 1'b0;
`endif

  assign w_seg_on  = w_lz ? SEG_BLANK : w_seg_ah;
  assign w_wrap    = (r_cnt == CNT_W'(DIV - 1));
  assign w_snap_en = r_first || (w_wrap && (r_idx == 3'd5));
  assign w_hot     = NUM_DIGITS'(1) << r_idx;

  generate
    if (BLANK == 0) begin : g_noblank
      assign w_sel_on = 1'b1;
    end else begin : g_blank
      assign w_sel_on = (r_cnt >= CNT_W'(BLANK));
    end
  endgenerate

  always_ff @(posedge fs) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_first <= 1'b1;
      r_snap  <= '0;
      r_dpm   <= '0;
      r_seg   <= SEG_OFF;
      r_dp    <= DP_OFF;
      r_sel   <= SEL_OFF;
    end else begin
      r_first <= 1'b0;
      if (w_snap_en) begin
        r_snap <= w_live;
        r_dpm  <= dp_mask;
      end
      if (w_wrap) begin
        r_cnt <= '0;
        r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      // Polarity is folded in last so the decode above stays active-high.
      r_seg <= w_seg_on ^ {SEG_W{SEG_ACTIVE_LOW}};
      r_dp  <= w_dpsrc[r_idx] ^ SEG_ACTIVE_LOW;
      r_sel <= w_sel_on ? (w_hot ^ {NUM_DIGITS{SEL_ACTIVE_LOW}}) : SEL_OFF;
    end
  end

  assign seg = r_seg;
  assign dp  = r_dp;
  assign sel = r_sel;

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan (DIV=4, BLANK=1, active-low seg and sel).
module tb_seg_scan;
  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int FRAME = 6 * DIV;

  logic       fs = 1'b0;
  logic       rst_n;
  logic [3:0] a, b, c, d, e, f;
  logic [5:0] dp_mask;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] sel;

  always #5 fs = ~fs;

  seg_scan #(
    .DIV(DIV), .BLANK(BLANK), .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)
  ) dut (
    .fs(fs), .rst_n(rst_n),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
    .dp_mask(dp_mask), .seg(seg), .dp(dp), .sel(sel)
  );

  int total = 0;
  int bad   = 0;

  // Model: p counts cycles since reset release; the frame/slot/phase follow by division.
  int         p     = 0;
  bit         m_vld = 1'b0;
  logic [3:0] m_snap [6];
  logic [5:0] m_dpm;
  logic [6:0] e_seg;
  logic       e_dp;
  logic [5:0] e_sel;
  int         m_slot, m_ph;
  logic [6:0] m_on;

  function automatic logic [6:0] pat(input logic [3:0] v);
    logic [6:0] r;
    case (v)
      4'd0: r = 7'h3F; 4'd1: r = 7'h06; 4'd2: r = 7'h5B; 4'd3: r = 7'h4F;
      4'd4: r = 7'h66; 4'd5: r = 7'h6D; 4'd6: r = 7'h7D; 4'd7: r = 7'h07;
      4'd8: r = 7'h7F; 4'd9: r = 7'h6F;
      default: r = 7'h00;
    endcase
    return r;
  endfunction

  always @(posedge fs) begin
    if (rst_n !== 1'b1) begin
      p     = 0;
      m_vld = 1'b1;
      e_sel = 6'h3F;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
    end else begin
      if (p == 0) begin
        m_snap = '{a, b, c, d, e, f};
        m_dpm  = dp_mask;
      end
      m_slot = (p / DIV) % 6;
      m_ph   = p % DIV;
      m_on   = pat(m_snap[m_slot]);
`ifdef LEAD_ZERO_BLANK_EN
      if (m_slot == 5 && m_snap[5] == 4'd0) m_on = 7'h00;
      if (m_slot == 4 && m_snap[5] == 4'd0 && m_snap[4] == 4'd0) m_on = 7'h00;
`endif
      e_seg = ~m_on;
      e_dp  = ~m_dpm[m_slot];
      e_sel = (m_ph >= BLANK) ? ~(6'b000001 << m_slot) : 6'h3F;
      if (p % FRAME == FRAME - 1) begin
        m_snap = '{a, b, c, d, e, f};
        m_dpm  = dp_mask;
      end
      p = p + 1;
    end
  end

  task automatic cmp(input string nm, input logic [6:0] act, input logic [6:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s pos=%0d got=%h want=%h", nm, p - 1, act, exp);
    end
  endtask

  task automatic step();
    @(negedge fs);
    if (m_vld) begin
      cmp("model_sel", {1'b0, sel}, {1'b0, e_sel});
      cmp("model_seg", seg, e_seg);
      cmp("model_dp", {6'd0, dp}, {6'd0, e_dp});
    end
  endtask

  task automatic wait_pos(input int target);
    int n = 0;
    while ((p - 1 != target) && (n < 400)) begin
      step();
      n++;
    end
    if (p - 1 != target) begin
      total++;
      bad++;
      $display("FAIL wait_pos target=%0d reached=%0d", target, p - 1);
    end
  endtask

  logic [5:0] walk_sel [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
  logic [6:0] walk_seg [6] = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};

  initial begin
    rst_n = 1'b0;
    a = 4'd1; b = 4'd2; c = 4'd3; d = 4'd4; e = 4'd5; f = 4'd6;
    dp_mask = 6'b000000;

    repeat (3) begin
      step();
      cmp("rst_sel", {1'b0, sel}, 7'h3F);
      cmp("rst_seg", seg, 7'h7F);
      cmp("rst_dp", {6'd0, dp}, 7'd1);
    end
    rst_n = 1'b1;
    step();
    cmp("rel0_sel", {1'b0, sel}, 7'h3F);
    step();
    cmp("rel1_sel", {1'b0, sel}, 7'h3E);

    for (int s = 0; s < 6; s++) begin
      wait_pos(s * DIV + 2);
      cmp("walk_sel", {1'b0, sel}, {1'b0, walk_sel[s]});
      cmp("walk_seg", seg, walk_seg[s]);
      wait_pos(s * DIV + 4);
      cmp("gap_sel", {1'b0, sel}, 7'h3F);
    end

    wait_pos(33);
    a = 4'd7;
    d = 4'd9;
    wait_pos(37);
    cmp("hold_seg", seg, 7'h19);
    wait_pos(49);
    cmp("a7_seg", seg, 7'h78);
    wait_pos(61);
    cmp("d9_seg", seg, 7'h10);

    c = 4'hA;
    dp_mask = 6'b000100;
    wait_pos(77);
    cmp("dp_off", {6'd0, dp}, 7'd1);
    wait_pos(81);
    cmp("ovf_sel", {1'b0, sel}, 7'h3B);
    cmp("ovf_seg", seg, 7'h7F);
    cmp("dp_on", {6'd0, dp}, 7'd0);

    wait_pos(86);
    f = 4'd0; e = 4'd0; d = 4'd5;
    wait_pos(109);
    cmp("lz_d_seg", seg, 7'h12);
`ifdef LEAD_ZERO_BLANK_EN
    wait_pos(113);
    cmp("lz_e_seg", seg, 7'h7F);
    wait_pos(117);
    cmp("lz_f_seg", seg, 7'h7F);
`else
    wait_pos(113);
    cmp("zero_e_seg", seg, 7'h40);
    wait_pos(117);
    cmp("zero_f_seg", seg, 7'h40);
`endif
    cmp("lz_f_sel", {1'b0, sel}, 7'h1F);
    f = 4'd1;
    wait_pos(137);
    cmp("e0_seg", seg, 7'h40);
    wait_pos(141);
    cmp("f1_seg", seg, 7'h79);

    wait_pos(157);
    rst_n = 1'b0;
    step();
    cmp("midrst_sel", {1'b0, sel}, 7'h3F);
    cmp("midrst_seg", seg, 7'h7F);
    cmp("midrst_dp", {6'd0, dp}, 7'd1);
    rst_n = 1'b1;
    step();
    step();
    cmp("restart_sel", {1'b0, sel}, 7'h3E);
    cmp("restart_seg", seg, 7'h78);
    repeat (30) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
